dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Two-requester arbiter sharing the single-port data RAM (mem_depth words × size bits, word-addressed) between the core load/store port (requester 0) and a debug/loader port (requester 1, program preload or state inspection).
- Sits between TOP_total's data-memory interface and the RAM instance.
- Issues one RAM access per cycle, returns registered read data, supports locked bursts, and guarantees requester 1 is not starved.

Parameters:
- size, 32, data word width in bits
- addr_w, 10, RAM word-address width (byte address bits [11:2])
- STARVE_LIMIT, 8, consecutive cycles requester 1 may wait before a forced grant

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTa  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  access request; held with its payload until granted
- we0, we1  in  1 each  1 = write, 0 = read
- lock0, lock1  in  1 each  keep ownership after this grant (burst)
- addr0, addr1  in  addr_w each  word address
- wdata0, wdata1  in  size each  write data
- gnt0, gnt1  out  1 each  combinational grant; access commits at this rising edge
- rvalid0, rvalid1  out  1 each  registered read-data valid, one cycle after a read grant
- rdata  out  size  registered read data, shared by both requesters
- ram_memwrite  out  1  RAM write enable
- ram_address  out  addr_w  RAM word address
- ram_write_data  out  size  RAM write data
- ram_read_data  in  size  RAM combinational read data

Behaviour:
- Reset (RSTa=1, asynchronous): state=IDLE, starve_cnt=0, last_owner=1, rvalid0/1=0, rdata=0. gnt0/1=0 and ram_memwrite=0 while RSTa is high.
- At most one gnt is high per cycle. ram_address, ram_write_data and ram_memwrite mirror the granted requester. With no grant: ram_memwrite=0, ram_address holds its last driven value, no access.
- States:
  - IDLE: arbitrate between req0 and req1. If the granted requester has lock=1, go to OWN0/OWN1.
  - OWN0: only requester 0 may be granted (when req0=1); requester 1 is never granted. Return to IDLE at the edge where lock0=0 is sampled together with a granted access, or at any edge where req0=0.
  - OWN1: symmetric to OWN0.
- Priority in IDLE: requester 0 wins unless the starvation override applies.
- Starvation counter (starve_cnt):
  - Increments each cycle req1=1 and gnt1=0; saturates at STARVE_LIMIT.
  - Clears to 0 when gnt1=1 or req1=0.
  - When starve_cnt==STARVE_LIMIT in IDLE, requester 1 wins.
  - In OWN0, the counter still counts; the override takes effect on the first IDLE cycle.
- Read path: on a granted read, at that edge rdata<=ram_read_data and rvalid<=1 for the owning requester only. Otherwise rvalid0/1<=0 and rdata holds. Read latency is exactly 1 cycle; back-to-back reads give continuous rvalid.
- Write path: a granted write commits at that edge. No rvalid is produced.
- Simultaneous read by one requester and write by the other to the same address: only the granted access occurs. The loser retries and sees the post-write data.
- Reset mid-burst: state returns to IDLE immediately and any pending rvalid is cleared.
- last_owner updates on every grant.

Optional Feature:
- Macro DRAM_ARB_ROUND_ROBIN_EN.
- Defined: IDLE arbitration is round-robin. When both requesters request, the one that is not last_owner wins. Starvation logic remains compiled but can never trigger beyond 1 cycle.
- Undefined: fixed priority to requester 0 with the STARVE_LIMIT override described above.

Test Plan:
- Reset: assert RSTa mid-simulation while req0=1 -> gnt0=0, rvalid0=0, rdata=0 during reset; first grant on the edge after release.
- Single access: req0, we0=1, addr0=5, wdata0=0xDEADBEEF; next cycle read addr0=5 -> gnt0 high in same cycle, rvalid0=1 with rdata=0xDEADBEEF one cycle later, rvalid1 stays 0.
- Contention (fixed priority): req0 and req1 held continuously, all reads -> gnt1 first high on cycle STARVE_LIMIT+1 (9th cycle), starve_cnt then clears; gnt0 gets all other cycles.
- Burst lock: req1 with lock1=1 for 4 reads at addr 0..3, then lock1=0 on the 5th, while req0 held -> gnt1 for 5 consecutive cycles, gnt0 never high during them, gnt0 the cycle after.
- Round-robin (DRAM_ARB_ROUND_ROBIN_EN defined): both requesters held -> gnt alternates 1,0,1,0 (last_owner=1 after reset, so requester 0 first).
- Write/read race: requester 1 writes 0x12345678 to addr 7 while requester 0 reads addr 7 with starvation override active -> gnt1 first; requester 0's read one cycle later returns 0x12345678.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port data RAM between the core load/store
// port (requester 0) and a debug/loader port (requester 1). One access is
// issued per cycle, read data comes back registered one cycle later, locked
// bursts keep ownership, and a starvation counter forces a grant to
// requester 1 after STARVE_LIMIT waiting cycles.
// Optional build macro: DRAM_ARB_ROUND_ROBIN_EN selects round-robin IDLE
// arbitration instead of fixed priority to requester 0.
module dram_arbiter #(
    parameter int size         = 32,
    parameter int addr_w       = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              CLK,
    input  logic              RSTa,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [addr_w-1:0] addr0,
    input  logic [addr_w-1:0] addr1,
    input  logic [size-1:0]   wdata0,
    input  logic [size-1:0]   wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [size-1:0]   rdata,
    output logic              ram_memwrite,
    output logic [addr_w-1:0] ram_address,
    output logic [size-1:0]   ram_write_data,
    input  logic [size-1:0]   ram_read_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                last_owner_q, last_owner_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [size-1:0]     rdata_q, rdata_d;
    logic [addr_w-1:0]   addr_hold_q, addr_hold_d;
    logic [size-1:0]     wdata_hold_q, wdata_hold_d;

    logic                starved;
    logic                pick1;
    logic                arb_gnt0;
    logic                arb_gnt1;
    logic                rd0;
    logic                rd1;

    // Tie-break choice used in IDLE when both requesters ask in the same cycle.
    always_comb begin
        starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`ifdef DRAM_ARB_ROUND_ROBIN_EN
        pick1 = starved | ~last_owner_q;
`else
        pick1 = starved;
`endif
    end

    // Grant selection and ownership state machine next-state logic.
    always_comb begin
        arb_gnt0 = 1'b0;
        arb_gnt1 = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    arb_gnt1 = pick1;
                    arb_gnt0 = ~pick1;
                end else begin
                    arb_gnt0 = req0;
                    arb_gnt1 = req1;
                end
                if (arb_gnt0 && lock0) begin
                    state_d = OWN0;
                end else if (arb_gnt1 && lock1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                arb_gnt0 = req0;
                if (!req0 || !lock0) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                arb_gnt1 = req1;
                if (!req1 || !lock1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Visible grants are suppressed while reset is held so nothing commits.
    always_comb begin
        gnt0 = arb_gnt0 & ~RSTa;
        gnt1 = arb_gnt1 & ~RSTa;
    end

    // RAM port mirrors the granted requester; address/data hold when idle.
    always_comb begin
        ram_memwrite   = (gnt0 & we0) | (gnt1 & we1);
        ram_address    = addr_hold_q;
        ram_write_data = wdata_hold_q;
        if (gnt1) begin
            ram_address    = addr1;
            ram_write_data = wdata1;
        end else if (gnt0) begin
            ram_address    = addr0;
            ram_write_data = wdata0;
        end
        addr_hold_d  = ram_address;
        wdata_hold_d = ram_write_data;
    end

    // Read return path: capture RAM data on a granted read, otherwise hold.
    always_comb begin
        rd0       = gnt0 & ~we0;
        rd1       = gnt1 & ~we1;
        rvalid0_d = rd0;
        rvalid1_d = rd1;
        rdata_d   = rdata_q;
        if (rd0 || rd1) begin
            rdata_d = ram_read_data;
        end
    end

    // Starvation counter for requester 1 and record of the last granted owner.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (gnt1 || !req1) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        last_owner_d = last_owner_q;
        if (gnt1) begin
            last_owner_d = 1'b1;
        end else if (gnt0) begin
            last_owner_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            last_owner_q <= 1'b1;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata_q      <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            last_owner_q <= last_owner_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata_q      <= rdata_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: self-checking bench for dram_arbiter with a behavioural
// RAM attached. Expected read data is queued when a read grant is expected
// and compared when rvalid should appear one cycle later.
module tb_dram_arbiter;

    localparam int SIZE = 32;
    localparam int AW   = 10;
    localparam int SL   = 8;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
    localparam int PRE  = 1;
`else
    localparam int PRE  = SL;
`endif

    logic            CLK = 1'b0;
    logic            RSTa;
    logic            req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0]   addr0, addr1;
    logic [SIZE-1:0] wdata0, wdata1;
    logic            gnt0, gnt1, rvalid0, rvalid1;
    logic [SIZE-1:0] rdata;
    logic            ram_memwrite;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic [SIZE-1:0] ram_read_data;

    logic [SIZE-1:0] mem     [0:(1<<AW)-1];
    logic [SIZE-1:0] ref_mem [0:(1<<AW)-1];

    typedef struct packed {
        logic            id;
        logic [SIZE-1:0] data;
    } sb_t;
    sb_t sb[$];

    int vectors    = 0;
    int miscompares = 0;

    dram_arbiter #(.size(SIZE), .addr_w(AW), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_memwrite(ram_memwrite), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port RAM: combinational read, write at the clock edge.
    assign ram_read_data = mem[ram_address];
    always @(posedge CLK) begin
        if (ram_memwrite) mem[ram_address] <= ram_write_data;
    end

    task automatic drive(input logic r0, input logic w0, input logic l0,
                         input logic [AW-1:0] a0, input logic [SIZE-1:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [AW-1:0] a1, input logic [SIZE-1:0] d1);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        RSTa = 1'b1;
        sb.delete();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RSTa = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        RSTa = 1'b1;
        drive(1, 0, 0, 10'd0, '0, 0, 0, 0, '0, '0);
        #2;
        vectors++;
        if (gnt0 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== '0 || ram_memwrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: gnt0=%b rvalid0=%b rvalid1=%b rdata=%h memwrite=%b, required all zero",
                     gnt0, rvalid0, rvalid1, rdata, ram_memwrite);
        end
        tick();
        vectors++;
        if (gnt0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_gnt_held: gnt0=%b, required 0", gnt0);
        end
        tick();
        RSTa = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
        end
        sb.push_back('{id: 1'b0, data: ref_mem[0]});
        tick();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge CLK);
        vectors++;
        e = sb.pop_front();
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== e.data) begin
            miscompares++;
            $display("[TB] FAIL reset_first_read: rvalid0=%b rvalid1=%b rdata=%h, required 1 0 %h",
                     rvalid0, rvalid1, rdata, e.data);
        end
        tick();
    endtask

    task automatic test_preload();
        logic [AW-1:0]   a_tab [6];
        logic [SIZE-1:0] d_tab [6];
        for (int i = 0; i < 5; i++) begin
            a_tab[i] = AW'(i);
            d_tab[i] = 32'h1000_0000 + SIZE'(i);
        end
        a_tab[5] = 10'd7;
        d_tab[5] = 32'hAAAA_0000;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, '0, '0, 1, 1, 0, a_tab[i], d_tab[i]);
            @(negedge CLK);
            vectors++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_memwrite !== 1'b1 ||
                ram_address !== a_tab[i] || ram_write_data !== d_tab[i]) begin
                miscompares++;
                $display("[TB] FAIL preload_write %0d: gnt0=%b gnt1=%b we=%b addr=%0d data=%h, required 0 1 1 %0d %h",
                         i, gnt0, gnt1, ram_memwrite, ram_address, ram_write_data, a_tab[i], d_tab[i]);
            end
            vectors++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL preload_no_rvalid %0d: rvalid0=%b rvalid1=%b, required 0 0", i, rvalid0, rvalid1);
            end
            ref_mem[a_tab[i]] = d_tab[i];
            tick();
        end
    endtask

    task automatic test_single_access();
        sb_t e;
        drive(1, 1, 0, 10'd5, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        @(negedge CLK);
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_memwrite !== 1'b1 ||
            ram_address !== 10'd5 || ram_write_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_write: gnt0=%b gnt1=%b we=%b addr=%0d data=%h, required 1 0 1 5 deadbeef",
                     gnt0, gnt1, ram_memwrite, ram_address, ram_write_data);
        end
        ref_mem[5] = 32'hDEADBEEF;
        tick();
        drive(1, 0, 0, 10'd5, '0, 0, 0, 0, '0, '0);
        @(negedge CLK);
        vectors++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_write_no_rvalid: rvalid0=%b rvalid1=%b, required 0 0", rvalid0, rvalid1);
        end
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_memwrite !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_read_grant: gnt0=%b gnt1=%b we=%b, required 1 0 0", gnt0, gnt1, ram_memwrite);
        end
        sb.push_back('{id: 1'b0, data: ref_mem[5]});
        tick();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge CLK);
        vectors++;
        e = sb.pop_front();
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== e.data) begin
            miscompares++;
            $display("[TB] FAIL single_read_data: rvalid0=%b rvalid1=%b rdata=%h, required 1 0 %h",
                     rvalid0, rvalid1, rdata, e.data);
        end
        vectors++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_memwrite !== 1'b0 || ram_address !== 10'd5) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: gnt0=%b gnt1=%b we=%b addr=%0d, required 0 0 0 5",
                     gnt0, gnt1, ram_memwrite, ram_address);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL rdata_hold: rvalid0=%b rvalid1=%b rdata=%h, required 0 0 deadbeef",
                     rvalid0, rvalid1, rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        sb_t  e;
        logic eg1;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            if (i < 20) drive(1, 0, 0, 10'd3, '0, 1, 0, 0, 10'd4, '0);
            else        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
            @(negedge CLK);
            vectors++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (rvalid0 !== ~e.id || rvalid1 !== e.id || rdata !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL contention_rdata cyc %0d: rvalid0=%b rvalid1=%b rdata=%h, required %b %b %h",
                             i, rvalid0, rvalid1, rdata, ~e.id, e.id, e.data);
                end
            end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL contention_rvalid cyc %0d: rvalid0=%b rvalid1=%b, required 0 0", i, rvalid0, rvalid1);
            end
            if (i < 20) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
                eg1 = (i % 2) == 1;
`else
                eg1 = (i % (SL + 1)) == SL;
`endif
                vectors++;
                if (gnt0 !== ~eg1 || gnt1 !== eg1 || ram_address !== (eg1 ? 10'd4 : 10'd3)) begin
                    miscompares++;
                    $display("[TB] FAIL contention_grant cyc %0d: gnt0=%b gnt1=%b addr=%0d, required %b %b %0d",
                             i, gnt0, gnt1, ram_address, ~eg1, eg1, eg1 ? 4 : 3);
                end
                sb.push_back('{id: eg1, data: eg1 ? ref_mem[4] : ref_mem[3]});
            end
            tick();
        end
    endtask

    task automatic test_burst_lock();
        sb_t e;
        logic eg1;
        do_reset();
        for (int i = 0; i < PRE + 7; i++) begin
            if (i < PRE)
                drive(1, 0, 0, 10'd3, '0, 1, 0, 1, 10'd0, '0);
            else if (i < PRE + 5)
                drive(1, 0, 0, 10'd3, '0, 1, 0, (i < PRE + 4), AW'(i - PRE), '0);
            else if (i == PRE + 5)
                drive(1, 0, 0, 10'd3, '0, 0, 0, 0, '0, '0);
            else
                drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
            @(negedge CLK);
            vectors++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (rvalid0 !== ~e.id || rvalid1 !== e.id || rdata !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL burst_rdata cyc %0d: rvalid0=%b rvalid1=%b rdata=%h, required %b %b %h",
                             i, rvalid0, rvalid1, rdata, ~e.id, e.id, e.data);
                end
            end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL burst_rvalid cyc %0d: rvalid0=%b rvalid1=%b, required 0 0", i, rvalid0, rvalid1);
            end
            if (i < PRE + 6) begin
                eg1 = (i >= PRE) && (i < PRE + 5);
                vectors++;
                if (gnt0 !== ~eg1 || gnt1 !== eg1) begin
                    miscompares++;
                    $display("[TB] FAIL burst_grant cyc %0d: gnt0=%b gnt1=%b, required %b %b", i, gnt0, gnt1, ~eg1, eg1);
                end
                sb.push_back('{id: eg1, data: eg1 ? ref_mem[i - PRE] : ref_mem[3]});
            end
            tick();
        end
    endtask

    task automatic test_race();
        sb_t e;
        logic eg1;
        do_reset();
        for (int i = 0; i < PRE + 3; i++) begin
            if (i < PRE)
                drive(1, 0, 0, 10'd3, '0, 1, 1, 0, 10'd7, 32'h12345678);
            else if (i == PRE)
                drive(1, 0, 0, 10'd7, '0, 1, 1, 0, 10'd7, 32'h12345678);
            else if (i == PRE + 1)
                drive(1, 0, 0, 10'd7, '0, 0, 0, 0, '0, '0);
            else
                drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
            @(negedge CLK);
            vectors++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (rvalid0 !== ~e.id || rvalid1 !== e.id || rdata !== e.data) begin
                    miscompares++;
                    $display("[TB] FAIL race_rdata cyc %0d: rvalid0=%b rvalid1=%b rdata=%h, required %b %b %h",
                             i, rvalid0, rvalid1, rdata, ~e.id, e.id, e.data);
                end
            end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL race_rvalid cyc %0d: rvalid0=%b rvalid1=%b, required 0 0", i, rvalid0, rvalid1);
            end
            if (i < PRE + 2) begin
                eg1 = (i == PRE);
                vectors++;
                if (gnt0 !== ~eg1 || gnt1 !== eg1 || ram_memwrite !== eg1) begin
                    miscompares++;
                    $display("[TB] FAIL race_grant cyc %0d: gnt0=%b gnt1=%b we=%b, required %b %b %b",
                             i, gnt0, gnt1, ram_memwrite, ~eg1, eg1, eg1);
                end
                if (eg1) ref_mem[7] = 32'h12345678;
                else     sb.push_back('{id: 1'b0, data: (i < PRE) ? ref_mem[3] : ref_mem[7]});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        sb_t e;
        do_reset();
        drive(0, 0, 0, '0, '0, 1, 0, 1, 10'd1, '0);
        @(negedge CLK);
        vectors++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_lock_grant: gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        tick();
        vectors++;
        if (rvalid1 !== 1'b1 || rdata !== ref_mem[1]) begin
            miscompares++;
            $display("[TB] FAIL midreset_pre_read: rvalid1=%b rdata=%h, required 1 %h", rvalid1, rdata, ref_mem[1]);
        end
        drive(1, 0, 0, 10'd5, '0, 1, 0, 1, 10'd2, '0);
        RSTa = 1'b1;
        sb.delete();
        #1;
        vectors++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== '0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_clear: rvalid0=%b rvalid1=%b rdata=%h gnt0=%b gnt1=%b, required 0 0 0 0 0",
                     rvalid0, rvalid1, rdata, gnt0, gnt1);
        end
        tick();
        RSTa = 1'b0;
        @(negedge CLK);
        vectors++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_release_grant: gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
        end
        sb.push_back('{id: 1'b0, data: ref_mem[5]});
        tick();
        drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        @(negedge CLK);
        vectors++;
        e = sb.pop_front();
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== e.data) begin
            miscompares++;
            $display("[TB] FAIL midreset_post_read: rvalid0=%b rvalid1=%b rdata=%h, required 1 0 %h",
                     rvalid0, rvalid1, rdata, e.data);
        end
        tick();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_preload();
        test_single_access();
        test_contention();
        test_burst_lock();
        test_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
